// File: rtl/axi_switch_pkg.sv
// Types and constants shared by the axi_switch write and read arbiters.
package axi_switch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } arb_state_e;

  localparam int unsigned ArbTimeoutDefault = 256;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at M-1 -> 0.
module rr_pick #(
  parameter int unsigned M     = 4,
  parameter int unsigned LOG_M = $clog2(M)
) (
  input  logic [M-1:0]     req,
  input  logic [LOG_M-1:0] ptr,
  output logic [LOG_M-1:0] win_idx,
  output logic             win_valid
);

  localparam int unsigned CW = LOG_M + 1;

  // One extra bit so ptr + offset cannot overflow before the modulo-M wrap.
  logic [CW-1:0] cand;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < M; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(M)) begin
        cand = cand - CW'(M);
      end
      if (!win_valid && req[cand[LOG_M-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[LOG_M-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Per-slave-port AXI write arbiter: round-robin grant locked across AW, W burst and B.
// Optional stall watchdog enabled by defining AXI_WR_ARB_WDOG_EN.
module axi_wr_arbiter
  import axi_switch_pkg::*;
#(
  parameter int unsigned M       = 4,
  parameter int unsigned LOG_M   = $clog2(M),
  parameter int unsigned TIMEOUT = ArbTimeoutDefault
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [M-1:0]     req,
  input  logic             aw_fire,
  input  logic             w_fire,
  input  logic             w_last,
  input  logic             b_fire,
  output logic [M-1:0]     gnt,
  output logic [LOG_M-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy,
  output logic             tmo_err
);

  arb_state_e       state_q, state_d;
  logic [LOG_M-1:0] ptr_q, ptr_d;
  logic [M-1:0]     gnt_q, gnt_d;
  logic [LOG_M-1:0] idx_q, idx_d;
  logic [LOG_M-1:0] win_idx;
  logic             win_valid;
  logic [LOG_M-1:0] next_ptr;
  logic             abort;

  rr_pick #(
    .M     (M),
    .LOG_M (LOG_M)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign next_ptr = (idx_q == LOG_M'(M - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          state_d        = StAddr;
        end
      end
      StAddr: begin
        // W beats before the AW handshake are not routed, so they cannot end the burst.
        if (aw_fire) begin
          state_d = (w_fire && w_last) ? StResp : StData;
        end
      end
      StData: begin
        if (w_fire && w_last) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (b_fire) begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      gnt_d   = '0;
      ptr_d   = next_ptr;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef AXI_WR_ARB_WDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q;

  // A B handshake in the abort cycle completes the transaction normally.
  assign abort = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT - 1)) &&
                 !((state_q == StResp) && b_fire);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_q == StIdle) || (state_d != state_q) || w_fire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= abort;
    end
  end

  assign tmo_err = tmo_q;
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign tmo_err    = 1'b0;
  assign unused_cfg = (TIMEOUT != 0);
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: vector table, directed corner sequences, random vs model.
module tb_axi_wr_arbiter;

  localparam int M   = 4;
  localparam int LM  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [M-1:0]  req;
  logic          aw_fire, w_fire, w_last, b_fire;
  logic [M-1:0]  gnt;
  logic [LM-1:0] gnt_idx;
  logic          gnt_valid, busy, tmo_err;

  int checks = 0;
  int errors = 0;

  axi_wr_arbiter #(
    .M       (M),
    .LOG_M   (LM),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .aw_fire   (aw_fire),
    .w_fire    (w_fire),
    .w_last    (w_last),
    .b_fire    (b_fire),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: owner (-1 = none), AW done, last W done, pointer, stall count.
  int m_owner = -1;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_aw, m_wl, m_tmo;

  task automatic model_clk();
    bit done, prog;
    m_tmo = 1'b0;
    if (!rstn) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_stall = 0; m_aw = 0; m_wl = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < M; k++) begin
        int j;
        j = (m_ptr + k) % M;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_idx   = j;
        end
      end
      m_aw = 0; m_wl = 0; m_stall = 0;
      return;
    end
    done = 0;
    prog = 0;
    if (!m_aw) begin
      if (aw_fire) begin
        m_aw = 1; prog = 1;
        if (w_fire && w_last) m_wl = 1;
      end
    end else if (!m_wl) begin
      if (w_fire && w_last) begin
        m_wl = 1; prog = 1;
      end
    end else if (b_fire) begin
      done = 1;
    end
`ifdef AXI_WR_ARB_WDOG_EN
    if (!done && m_stall == TMO - 1) begin
      m_tmo = 1;
      done  = 1;
    end
`endif
    if (done) begin
      m_ptr   = (m_owner + 1) % M;
      m_owner = -1;
    end else if (prog || w_fire) begin
      m_stall = 0;
    end else begin
      m_stall++;
    end
  endtask

  task automatic drive(input logic r, input logic [M-1:0] q, input logic a, input logic w,
                       input logic l, input logic b);
    rstn = r; req = q; aw_fire = a; w_fire = w; w_last = l; b_fire = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_clk();
  endtask

  task automatic check(input string name, input logic [M-1:0] eg, input int ei,
                       input logic eb, input logic et);
    checks++;
    if (gnt !== eg || gnt_idx !== LM'(ei) || gnt_valid !== (|eg) || busy !== eb ||
        tmo_err !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b busy=%b tmo=%b, expected gnt=%b idx=%0d valid=%b busy=%b tmo=%b",
               name, gnt, gnt_idx, gnt_valid, busy, tmo_err, eg, ei, |eg, eb, et);
    end
  endtask

  task automatic check_model(input string name);
    logic [M-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check(name, eg, m_idx, m_owner >= 0, m_tmo);
  endtask

  typedef struct {
    string        name;
    logic         r;
    logic [M-1:0] q;
    logic         a, w, l, b;
    logic [M-1:0] eg;
    int           ei;
    logic         eb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string n, input logic r, input logic [M-1:0] q,
                              input logic a, input logic w, input logic l, input logic b,
                              input logic [M-1:0] eg, input int ei, input logic eb);
    vec_t v;
    v.name = n; v.r = r; v.q = q; v.a = a; v.w = w; v.l = l; v.b = b;
    v.eg = eg; v.ei = ei; v.eb = eb;
    tbl.push_back(v);
  endfunction

  initial begin
    drive(1'b0, '0, 0, 0, 0, 0);

    //  name              rstn req     aw w  wl b  gnt     idx busy
    add("reset",          0,   4'h0,   0, 0, 0, 0, 4'h0,   0,  0);
    add("grant_m2",       1,   4'b0100,0, 0, 0, 0, 4'b0100,2,  1);
    add("aw_to_data",     1,   4'b0100,1, 0, 0, 0, 4'b0100,2,  1);
    add("beat1",          1,   4'b0100,0, 1, 0, 0, 4'b0100,2,  1);
    add("beat2_b_ign",    1,   4'b0100,0, 1, 0, 1, 4'b0100,2,  1);
    add("beat3_last",     1,   4'b0100,0, 1, 1, 0, 4'b0100,2,  1);
    add("resp_done",      1,   4'b0100,0, 0, 0, 1, 4'h0,   2,  0);
    add("ptr3_pick_m3",   1,   4'b1001,0, 0, 0, 0, 4'b1000,3,  1);
    add("single_beat",    1,   4'b1001,1, 1, 1, 0, 4'b1000,3,  1);
    add("single_resp",    1,   4'b1001,0, 0, 0, 1, 4'h0,   3,  0);
    add("wrap_pick_m0",   1,   4'b1001,0, 0, 0, 0, 4'b0001,0,  1);
    add("addr_b_ign",     1,   4'b1001,0, 0, 0, 1, 4'b0001,0,  1);
    add("addr_w_ign",     1,   4'b1001,0, 1, 1, 0, 4'b0001,0,  1);
    add("aw_after_w",     1,   4'b1001,1, 0, 0, 0, 4'b0001,0,  1);
    add("last_in_data",   1,   4'b0000,0, 1, 1, 0, 4'b0001,0,  1);
    add("resp_req_drop",  1,   4'b0000,0, 0, 0, 0, 4'b0001,0,  1);
    add("resp_done2",     1,   4'b0000,0, 0, 0, 1, 4'h0,   0,  0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].q, tbl[i].a, tbl[i].w, tbl[i].l, tbl[i].b);
      step();
      check(tbl[i].name, tbl[i].eg, tbl[i].ei, tbl[i].eb, 1'b0);
    end

    // Fairness: all masters requesting, grants must run 0,1,2,3,0 with no overlap.
    drive(1'b0, '0, 0, 0, 0, 0);
    step();
    for (int t = 0; t < 5; t++) begin
      logic [M-1:0] eg;
      eg = '0;
      eg[t % M] = 1'b1;
      drive(1'b1, 4'b1111, 0, 0, 0, 0);
      step();
      check("rr_grant", eg, t % M, 1'b1, 1'b0);
      drive(1'b1, 4'b1111, 1, 1, 1, 0);
      step();
      check("rr_resp", eg, t % M, 1'b1, 1'b0);
      drive(1'b1, 4'b1111, 0, 0, 0, 1);
      step();
      check("rr_release", 4'h0, t % M, 1'b0, 1'b0);
    end

    // Reset mid-burst: ptr is 3 beforehand, so 4'b1010 picks master 1 only if ptr was cleared.
    drive(1'b0, '0, 0, 0, 0, 0);
    step();
    drive(1'b1, 4'b0100, 0, 0, 0, 0); step();
    drive(1'b1, 4'b0100, 1, 1, 1, 0); step();
    drive(1'b1, 4'b0000, 0, 0, 0, 1); step();
    drive(1'b1, 4'b0010, 0, 0, 0, 0); step();
    check("mid_grant_m1", 4'b0010, 1, 1'b1, 1'b0);
    drive(1'b1, 4'b0010, 1, 0, 0, 0); step();
    drive(1'b1, 4'b0010, 0, 1, 0, 0); step();
    check("mid_in_data", 4'b0010, 1, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 0, 1, 0, 0); step();
    check("mid_reset", 4'h0, 0, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 0, 0, 0, 0); step();
    check("post_reset_ptr0", 4'b0010, 1, 1'b1, 1'b0);

    // Watchdog: grant master 2, AW, then no W beats.
    drive(1'b0, '0, 0, 0, 0, 0); step();
    drive(1'b1, 4'b0100, 0, 0, 0, 0); step();
    drive(1'b1, 4'b0100, 1, 0, 0, 0); step();
    check("wd_in_data", 4'b0100, 2, 1'b1, 1'b0);
    drive(1'b1, 4'b0100, 0, 0, 0, 0);
    for (int n = 1; n <= 40; n++) begin
      step();
`ifdef AXI_WR_ARB_WDOG_EN
      if (n < TMO) check("wd_hold", 4'b0100, 2, 1'b1, 1'b0);
      else if (n == TMO) check("wd_abort", 4'h0, 2, 1'b0, 1'b1);
      if (n == TMO) begin
        drive(1'b1, 4'b1111, 0, 0, 0, 0);
        step();
        check("wd_next_m3", 4'b1000, 3, 1'b1, 1'b0);
        break;
      end
`else
      check("wd_hold", 4'b0100, 2, 1'b1, 1'b0);
`endif
    end

    // Randomised traffic against the model, with varying activity levels and rare resets.
    drive(1'b0, '0, 0, 0, 0, 0);
    step();
    check_model("rand_reset");
    for (int blk = 0; blk < 40; blk++) begin
      int act;
      act = $urandom_range(100, 3);
      for (int c = 0; c < 64; c++) begin
        logic w;
        w = ($urandom_range(99) < act);
        drive(($urandom_range(299) != 0), 4'($urandom), ($urandom_range(99) < act), w,
              w && ($urandom_range(3) == 0), ($urandom_range(99) < act));
        step();
        check_model("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
